// File: rtl/stack_unit_if.sv
// -----------------------------------------------------------------------------
// stack_unit_if
// Strobe/data bundle between the stack processor datapath and its operand
// stack. The datapath drives the strobes and write data (master); the stack
// returns the registered top word and status (slave).
//
// Signals
//   push, pop, tos : operation strobes, one operation per cycle
//   din            : word to push
//   dout           : registered top/popped word
//   empty, full    : occupancy status
//   overflow       : sticky push-while-full flag (0 unless guards are built)
//   underflow      : sticky pop/tos-while-empty flag (0 unless guards are built)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface stack_unit_if #(
   parameter int WIDTH = 8
);
   logic             push;
   logic             pop;
   logic             tos;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;

   modport master (
      output push, pop, tos, din,
      input  dout, empty, full, overflow, underflow
   );

   modport slave (
      input  push, pop, tos, din,
      output dout, empty, full, overflow, underflow
   );
endinterface : stack_unit_if

// File: rtl/stack_unit.sv
// -----------------------------------------------------------------------------
// stack_unit
// Operand stack for the multi-cycle stack processor. Holds up to DEPTH words;
// the top-of-stack word is returned through a registered output that the
// datapath latches in its next state. One operation is accepted every cycle.
//
// Parameters
//   WIDTH : data word width (must match the interface WIDTH)
//   DEPTH : number of entries, at least 2
//
// Ports
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-low; clears count, dout and error flags
//   bus   : stack_unit_if.slave (push/pop/tos/din in, dout/empty/full/
//           overflow/underflow out)
//
// Configuration
//   STACK_GUARD_EN : when defined, overflow/underflow are sticky registers set
//                    by illegal operations; otherwise both outputs are tied
//                    to 0. Illegal operations are dropped in both builds.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module stack_unit #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input logic          clk,
   input logic          reset,
   stack_unit_if.slave  bus
);

   localparam int CW = $clog2(DEPTH + 1);   // count width, holds 0..DEPTH
   localparam int AW = $clog2(DEPTH);       // storage index width

   // Action taken on the coming edge after priority decode and legality check.
   typedef enum logic [2:0] {
      OP_NONE,
      OP_PUSH,
      OP_POP,
      OP_TOS,
      OP_REPLACE
   } op_e;

   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_dout;
   logic [WIDTH-1:0] r_mem [DEPTH];

   logic             w_empty;
   logic             w_full;
   logic [AW-1:0]    w_top_idx;
   logic [AW-1:0]    w_wr_idx;
   op_e              w_op;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CW'(DEPTH));
   // Only used when the stack is non-empty (top) or not full (write slot),
   // so truncation to the index width is exact in those cases.
   assign w_top_idx = AW'(r_count - CW'(1));
   assign w_wr_idx  = AW'(r_count);

   // Priority decode: push&pop > push > pop > tos. Illegal requests become
   // OP_NONE, except push&pop on an empty stack which degrades to a push.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      w_op = OP_NONE;
      if (bus.push && bus.pop) begin
         w_op = w_empty ? OP_PUSH : OP_REPLACE;
      end else if (bus.push) begin
         if (!w_full) w_op = OP_PUSH;
      end else if (bus.pop) begin
         if (!w_empty) w_op = OP_POP;
      end else if (bus.tos) begin
         if (!w_empty) w_op = OP_TOS;
      end
   end

   // Control state: occupancy and the registered output word.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!reset) begin
         r_count <= '0;
         r_dout  <= '0;
      end else begin
         case (w_op)
            OP_PUSH: r_count <= r_count + CW'(1);
            OP_POP: begin
               r_dout  <= r_mem[w_top_idx];
               r_count <= r_count - CW'(1);
            end
            OP_TOS,
            OP_REPLACE: r_dout <= r_mem[w_top_idx];
            default: ;
         endcase
      end
   end

   // NOTE: storage has no reset; entries are only ever read after being
   // written, so clearing them would buy nothing.
   always_ff @(posedge clk) begin
      case (w_op)
         OP_PUSH:    r_mem[w_wr_idx]  <= bus.din;
         OP_REPLACE: r_mem[w_top_idx] <= bus.din;
         default: ;
      endcase
   end

   assign bus.dout  = r_dout;
   assign bus.empty = w_empty;
   assign bus.full  = w_full;

`ifdef STACK_GUARD_EN
   logic r_overflow;
   logic r_underflow;
   logic w_ovf_evt;
   logic w_unf_evt;

   // tos is ignored under push, so push+tos on an empty stack is legal.
   assign w_ovf_evt = bus.push && !bus.pop && w_full;
   assign w_unf_evt = w_empty && (bus.pop || (bus.tos && !bus.push));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_ovf_evt) r_overflow  <= 1'b1;
         if (w_unf_evt) r_underflow <= 1'b1;
      end
   end

   assign bus.overflow  = r_overflow;
   assign bus.underflow = r_underflow;
`else
   assign bus.overflow  = 1'b0;
   assign bus.underflow = 1'b0;
`endif

endmodule : stack_unit

// File: tb/tb_stack_unit.sv
// -----------------------------------------------------------------------------
// tb_stack_unit
// Self-checking bench for stack_unit (WIDTH 8, DEPTH 16). A queue-based
// reference model tracks contents, the last returned word and the sticky
// error flags; every operation is followed by a full output comparison.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_stack_unit;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;

   logic clk;
   logic reset;

   stack_unit_if #(.WIDTH(WIDTH)) su_bus ();

   stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (su_bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [WIDTH-1:0] m_stack[$];   // back of queue = top of stack
   logic [WIDTH-1:0] m_dout;
   bit               m_ovf;
   bit               m_unf;

   task automatic check(input string tag, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic void model_clear();
      m_stack.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
   endfunction

   function automatic void model_step(input bit p, input bit po, input bit t,
                                      input logic [WIDTH-1:0] d);
      int n;
      n = m_stack.size();
      if (p && po) begin
         if (n > 0) begin
            m_dout = m_stack[n-1];
            m_stack[n-1] = d;
         end else begin
            m_stack.push_back(d);
            m_unf = 1'b1;
         end
      end else if (p) begin
         if (n < DEPTH) m_stack.push_back(d);
         else           m_ovf = 1'b1;
      end else if (po) begin
         if (n > 0) m_dout = m_stack.pop_back();
         else       m_unf = 1'b1;
      end else if (t) begin
         if (n > 0) m_dout = m_stack[n-1];
         else       m_unf = 1'b1;
      end
   endfunction

   task automatic check_all(input string tag);
      bit e_ovf;
      bit e_unf;
`ifdef STACK_GUARD_EN
      e_ovf = m_ovf;
      e_unf = m_unf;
`else
      e_ovf = 1'b0;
      e_unf = 1'b0;
`endif
      check({tag, ".dout"},  32'(su_bus.dout),      32'(m_dout));
      check({tag, ".empty"}, 32'(su_bus.empty),     32'(m_stack.size() == 0));
      check({tag, ".full"},  32'(su_bus.full),      32'(m_stack.size() == DEPTH));
      check({tag, ".ovf"},   32'(su_bus.overflow),  32'(e_ovf));
      check({tag, ".unf"},   32'(su_bus.underflow), 32'(e_unf));
   endtask

   // Drive at the falling edge, model at the rising edge, sample 1ns later.
   task automatic do_op(input bit p, input bit po, input bit t,
                        input logic [WIDTH-1:0] d, input string tag);
      @(negedge clk);
      su_bus.push = p;
      su_bus.pop  = po;
      su_bus.tos  = t;
      su_bus.din  = d;
      @(posedge clk);
      model_step(p, po, t, d);
      #1;
      check_all(tag);
   endtask

   // Assert reset away from any clock edge, check the immediate effect,
   // then release it on a falling edge.
   task automatic apply_reset(input string tag);
      su_bus.push = 1'b0;
      su_bus.pop  = 1'b0;
      su_bus.tos  = 1'b0;
      su_bus.din  = '0;
      #2;
      reset = 1'b0;
      #1;
      model_clear();
      check_all(tag);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      model_clear();
      apply_reset("por");

      // LIFO order
      do_op(1, 0, 0, 8'h11, "lifo.push");
      do_op(1, 0, 0, 8'h22, "lifo.push");
      do_op(1, 0, 0, 8'h33, "lifo.push");
      do_op(0, 1, 0, 8'h00, "lifo.pop1");
      do_op(0, 1, 0, 8'h00, "lifo.pop2");
      do_op(0, 1, 0, 8'h00, "lifo.pop3");

      // tos does not consume
      do_op(1, 0, 0, 8'hA5, "tos.push");
      do_op(0, 0, 1, 8'h00, "tos.1");
      do_op(0, 0, 1, 8'h00, "tos.2");
      do_op(0, 1, 0, 8'h00, "tos.pop");

      // fill, overflow drop, pop returns last accepted word
      for (int i = 0; i < DEPTH; i++) do_op(1, 0, 0, WIDTH'(i), "fill");
      do_op(1, 0, 0, 8'hFF, "fill.over");
      do_op(0, 1, 0, 8'h00, "fill.pop");
      check("fill.pop_val", 32'(su_bus.dout), 32'h0F);

      // underflow from reset
      apply_reset("rst1");
      do_op(0, 1, 0, 8'h00, "unf.pop");
      do_op(0, 0, 1, 8'h00, "unf.tos");

      // replace-top
      apply_reset("rst2");
      do_op(1, 0, 0, 8'h44, "rep.push");
      do_op(1, 1, 0, 8'h55, "rep.swap");
      check("rep.swap_val", 32'(su_bus.dout), 32'h44);
      do_op(0, 1, 0, 8'h00, "rep.pop");
      check("rep.pop_val", 32'(su_bus.dout), 32'h55);
      do_op(1, 1, 0, 8'h77, "rep.empty");   // push&pop on empty: push + underflow

      // randomized: alternate push-heavy and pop-heavy phases
      apply_reset("rst3");
      for (int ph = 0; ph < 8; ph++) begin
         for (int k = 0; k < 40; k++) begin
            int r;
            bit p, po, t;
            r  = int'($urandom_range(0, 99));
            p  = (ph % 2 == 0) ? (r < 60) : (r < 20);
            po = (ph % 2 == 0) ? (r >= 50 && r < 65) : (r >= 15 && r < 75);
            t  = ($urandom_range(0, 3) == 0);
            do_op(p, po, t, WIDTH'($urandom), "rand");
         end
      end

      // asynchronous reset mid-cycle
      apply_reset("rst4");
      do_op(1, 0, 0, 8'h66, "arst.push");
      do_op(0, 0, 1, 8'h00, "arst.tos");
      apply_reset("arst");
      do_op(0, 1, 0, 8'h00, "arst.pop");
      check("arst.pop_val", 32'(su_bus.dout), 32'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_stack_unit
